inst_decoder: RTL and testbench



---
 rtl/inst_decoder.sv | 190 +++++++++++++++++++
 tb/tb_inst_decoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/inst_decoder.sv
// RV32I decode stage: register-index and upper-immediate slices, one-hot instruction identity, invalid flag.
// Define ZICSR_EN to decode the CSR instructions and MRET (flags 41-47); otherwise they are tied to 0.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module inst_decoder (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`MAX_BIT_POS:0] instruction_code,
  input  logic                  en,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [19:0]           imm_1231,
  output logic                  invalid_instruction,
  output logic [47:0]           inst_flags
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [`MAX_BIT_POS:0] W_ECALL  = 32'h0000_0073;
  localparam logic [`MAX_BIT_POS:0] W_EBREAK = 32'h0010_0073;
`ifdef ZICSR_EN
  localparam logic [`MAX_BIT_POS:0] W_MRET   = 32'h3020_0073;
`endif

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [47:0] w_flags;

  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [19:0] r_imm_1231;
  logic        r_invalid;
  logic [47:0] r_flags;

  assign w_opcode = instruction_code[6:0];
  assign w_f3     = instruction_code[14:12];
  assign w_f7     = instruction_code[31:25];

  always_comb begin
    w_flags = '0;
    case (w_opcode)
      OP_LUI:   w_flags[0] = 1'b1;
      OP_AUIPC: w_flags[1] = 1'b1;
      OP_JAL:   w_flags[2] = 1'b1;
      OP_JALR:  w_flags[3] = (w_f3 == 3'b000);
      OP_BRANCH: begin
        case (w_f3)
          3'b000:  w_flags[4] = 1'b1;
          3'b001:  w_flags[5] = 1'b1;
          3'b100:  w_flags[6] = 1'b1;
          3'b101:  w_flags[7] = 1'b1;
          3'b110:  w_flags[8] = 1'b1;
          3'b111:  w_flags[9] = 1'b1;
          default: ;
        endcase
      end
      OP_LOAD: begin
        case (w_f3)
          3'b000:  w_flags[10] = 1'b1;
          3'b001:  w_flags[11] = 1'b1;
          3'b010:  w_flags[12] = 1'b1;
          3'b100:  w_flags[13] = 1'b1;
          3'b101:  w_flags[14] = 1'b1;
          default: ;
        endcase
      end
      OP_STORE: begin
        case (w_f3)
          3'b000:  w_flags[15] = 1'b1;
          3'b001:  w_flags[16] = 1'b1;
          3'b010:  w_flags[17] = 1'b1;
          default: ;
        endcase
      end
      OP_IMM: begin
        case (w_f3)
          3'b000: w_flags[18] = 1'b1;
          3'b010: w_flags[19] = 1'b1;
          3'b011: w_flags[20] = 1'b1;
          3'b100: w_flags[21] = 1'b1;
          3'b110: w_flags[22] = 1'b1;
          3'b111: w_flags[23] = 1'b1;
          3'b001: w_flags[24] = (w_f7 == F7_BASE);
          3'b101: begin
            w_flags[25] = (w_f7 == F7_BASE);
            w_flags[26] = (w_f7 == F7_ALT);
          end
          default: ;
        endcase
      end
      OP_REG: begin
        case (w_f3)
          3'b000: begin
            w_flags[27] = (w_f7 == F7_BASE);
            w_flags[28] = (w_f7 == F7_ALT);
          end
          3'b001: w_flags[29] = (w_f7 == F7_BASE);
          3'b010: w_flags[30] = (w_f7 == F7_BASE);
          3'b011: w_flags[31] = (w_f7 == F7_BASE);
          3'b100: w_flags[32] = (w_f7 == F7_BASE);
          3'b101: begin
            w_flags[33] = (w_f7 == F7_BASE);
            w_flags[34] = (w_f7 == F7_ALT);
          end
          3'b110: w_flags[35] = (w_f7 == F7_BASE);
          3'b111: w_flags[36] = (w_f7 == F7_BASE);
          default: ;
        endcase
      end
      OP_FENCE: begin
        w_flags[37] = (w_f3 == 3'b000);
        w_flags[38] = (w_f3 == 3'b001);
      end
      OP_SYSTEM: begin
        // Full-word matches take priority over the funct3-based CSR decode.
        if (instruction_code == W_ECALL) begin
          w_flags[39] = 1'b1;
        end else if (instruction_code == W_EBREAK) begin
          w_flags[40] = 1'b1;
`ifdef ZICSR_EN
        end else if (instruction_code == W_MRET) begin
          w_flags[47] = 1'b1;
        end else begin
          case (w_f3)
            3'b001:  w_flags[41] = 1'b1;
            3'b010:  w_flags[42] = 1'b1;
            3'b011:  w_flags[43] = 1'b1;
            3'b101:  w_flags[44] = 1'b1;
            3'b110:  w_flags[45] = 1'b1;
            3'b111:  w_flags[46] = 1'b1;
            default: ;
          endcase
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm_1231 <= '0;
      r_invalid  <= 1'b0;
      r_flags    <= '0;
    end else if (en) begin
      r_rd       <= instruction_code[11:7];
      r_rs1      <= instruction_code[19:15];
      r_rs2      <= instruction_code[24:20];
      r_imm_1231 <= instruction_code[31:12];
      r_invalid  <= ~|w_flags;
      r_flags    <= w_flags;
    end else begin
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm_1231 <= '0;
      r_invalid  <= 1'b0;
      r_flags    <= '0;
    end
  end

  assign rd                  = r_rd;
  assign rs1                 = r_rs1;
  assign rs2                 = r_rs2;
  assign imm_1231            = r_imm_1231;
  assign invalid_instruction = r_invalid;
  assign inst_flags          = r_flags;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed-vector bench for inst_decoder; expected fields are hand-derived from each instruction word.
`timescale 1ns/1ps

module tb_inst_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction_code;
  logic        en;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [19:0] imm_1231;
  logic        invalid_instruction;
  logic [47:0] inst_flags;

  int unsigned n_cmp;
  int unsigned n_err;

  inst_decoder u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_code    (instruction_code),
    .en                  (en),
    .rd                  (rd),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .imm_1231            (imm_1231),
    .invalid_instruction (invalid_instruction),
    .inst_flags          (inst_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] onehot(input int idx);
    logic [47:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check_all(input string tag, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                           input logic [4:0] e_rs2, input logic [19:0] e_imm,
                           input logic e_inv, input int e_flag);
    check({tag, ".rd"},    64'(rd),                  64'(e_rd));
    check({tag, ".rs1"},   64'(rs1),                 64'(e_rs1));
    check({tag, ".rs2"},   64'(rs2),                 64'(e_rs2));
    check({tag, ".imm"},   64'(imm_1231),            64'(e_imm));
    check({tag, ".inv"},   64'(invalid_instruction), 64'(e_inv));
    check({tag, ".flags"}, 64'(inst_flags),          64'(onehot(e_flag)));
  endtask

  // Drive away from the edge, then sample 1 ns after the capturing edge.
  task automatic step(input logic [31:0] word, input logic e);
    instruction_code = word;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string tag, input logic [31:0] word, input logic [4:0] e_rd,
                     input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic e_inv,
                     input int e_flag);
    step(word, 1'b1);
    check_all(tag, e_rd, e_rs1, e_rs2, word[31:12], e_inv, e_flag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b1;
    instruction_code = 32'h0010_8163;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 5'd0, 5'd0, 5'd0, 20'h0, 1'b0, -1);

    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_after_reset", 5'd2, 5'd1, 5'd1, 20'h00108, 1'b0, 4);

    dec("BEQ",    32'h0010_8163, 5'd2,  5'd1,  5'd1,  1'b0, 4);
    dec("ADDI",   32'h0050_8113, 5'd2,  5'd1,  5'd5,  1'b0, 18);
    dec("LW",     32'h0041_2083, 5'd1,  5'd2,  5'd4,  1'b0, 12);
    dec("AND",    32'h0020_F1B3, 5'd3,  5'd1,  5'd2,  1'b0, 36);
    dec("SUB",    32'h4020_8033, 5'd0,  5'd1,  5'd2,  1'b0, 28);
    dec("BADF7",  32'h4220_8033, 5'd0,  5'd1,  5'd2,  1'b1, -1);
    dec("SRAI",   32'h4000_5013, 5'd0,  5'd0,  5'd0,  1'b0, 26);
    dec("JALRF3", 32'h0000_1067, 5'd0,  5'd0,  5'd0,  1'b1, -1);
    dec("ECALL",  32'h0000_0073, 5'd0,  5'd0,  5'd0,  1'b0, 39);
    dec("EBREAK", 32'h0010_0073, 5'd0,  5'd0,  5'd1,  1'b0, 40);
    dec("ONES",   32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31, 1'b1, -1);

    step(32'h0000_0000, 1'b0);
    check_all("en_low", 5'd0, 5'd0, 5'd0, 20'h0, 1'b0, -1);
    step(32'hFFFF_FFFF, 1'b0);
    check_all("en_low_bad", 5'd0, 5'd0, 5'd0, 20'h0, 1'b0, -1);

`ifdef ZICSR_EN
    dec("MRET",  32'h3020_0073, 5'd0, 5'd0, 5'd2, 1'b0, 47);
    dec("CSRRW", 32'h0000_1073, 5'd0, 5'd0, 5'd0, 1'b0, 41);
`else
    dec("MRET",  32'h3020_0073, 5'd0, 5'd0, 5'd2, 1'b1, -1);
    dec("CSRRW", 32'h0000_1073, 5'd0, 5'd0, 5'd0, 1'b1, -1);
`endif

    // Reset asserted mid-cycle must clear the outputs before any clock edge.
    dec("LW_again", 32'h0041_2083, 5'd1, 5'd2, 5'd4, 1'b0, 12);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 5'd0, 5'd0, 5'd0, 20'h0, 1'b0, -1);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
